// File: rtl/lowpass.sv
// First-order IIR low-pass: y tracks u with coefficient alpha = 2^-L2_ALPHA.
// The accumulator keeps y scaled by 2^L2_ALPHA, so the fractional bits are never dropped.
module lowpass #(
  parameter int WIDTH    = 32,
  parameter int L2_ALPHA = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] u,
  output logic [WIDTH-1:0] y
);

  localparam int AW = WIDTH + L2_ALPHA;  // accumulator width
  localparam int SW = AW + 2;            // headroom for the update sum

  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] leak;
  logic signed [SW-1:0] acc_ext, u_ext, leak_ext, sum;
  logic                 ovf;

  always_comb begin
    // NOTE: every variable gets a default at the top, so no path can infer a latch.
    acc_d    = acc_q;
    leak     = acc_q >>> L2_ALPHA;
    acc_ext  = {{2{acc_q[AW-1]}}, acc_q};
    u_ext    = {{(SW-WIDTH){u[WIDTH-1]}}, u};
    leak_ext = {{2{leak[AW-1]}}, leak};
    sum      = acc_ext + u_ext - leak_ext;
    // The top three bits agree only when the sum fits the accumulator's range.
    ovf      = (sum[SW-1:AW-1] != {3{sum[SW-1]}});
    if (en) begin
      if (ovf) begin
        acc_d = sum[SW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      end else begin
        acc_d = sum[AW-1:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Dropping the low bits is an arithmetic shift right: floor toward minus infinity.
  assign y = acc_q[AW-1:L2_ALPHA];

endmodule

// File: tb/tb_lowpass.sv
// Self-checking bench for lowpass: directed vector table, corner-case sequences,
// and random stimulus against an arithmetic reference model.
module tb_lowpass;

  localparam int     W     = 32;
  localparam int     L2    = 5;
  localparam longint SCALE = longint'(1) << L2;
  localparam longint AMAX  = (longint'(1) << (W + L2 - 1)) - 1;
  localparam longint AMIN  = -(longint'(1) << (W + L2 - 1));
  localparam int     UMAX  = 32'sh7fff_ffff;
  localparam int     UMIN  = 32'sh8000_0000;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en  = 1'b0;
  logic signed [W-1:0] u  = '0;
  logic signed [W-1:0] y;

  int     checks = 0;
  int     errors = 0;
  longint macc   = 0;

  lowpass #(.WIDTH(W), .L2_ALPHA(L2)) dut (
    .clk(clk),
    .rst(rst),
    .en (en),
    .u  (u),
    .y  (y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic   rst;
    logic   en;
    int     u;
    longint exp_acc;
    longint exp_y;
  } vec_t;

  vec_t vecs[$];

  function automatic longint floor_div(longint a, longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint model_next(longint a, int uv);
    longint s;
    s = a + longint'(uv) - floor_div(a, SCALE);
    if (s > AMAX) s = AMAX;
    if (s < AMIN) s = AMIN;
    return s;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one clock cycle and advance the model; returns #1 after the edge.
  task automatic cycle(input logic r, input logic e, input int uv);
    rst = r;
    en  = e;
    u   = uv;
    if (r) macc = 0;
    @(posedge clk);
    if (!r && e) macc = model_next(macc, uv);
    #1;
  endtask

  longint dut_acc;
  assign dut_acc = dut.acc_q;

  initial begin
    logic   ok;
    longint prev;

    // Directed vectors: steps, hold with random u, reset priority.
    vecs.push_back('{1'b1, 1'b0, 0,   0,   0});
    vecs.push_back('{1'b0, 1'b1, 32,  32,  1});
    vecs.push_back('{1'b0, 1'b1, 32,  63,  1});
    vecs.push_back('{1'b0, 1'b1, 32,  94,  2});
    for (int i = 0; i < 10; i++)
      vecs.push_back('{1'b0, 1'b0, int'($urandom), 94, 2});
    vecs.push_back('{1'b1, 1'b1, 500, 0,   0});
    vecs.push_back('{1'b0, 1'b1, -32, -32, -1});
    vecs.push_back('{1'b0, 1'b1, -32, -63, -2});

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].en, vecs[i].u);
      check($sformatf("vec%0d_acc", i), dut_acc, vecs[i].exp_acc);
      check($sformatf("vec%0d_y", i), longint'(y), vecs[i].exp_y);
    end

    // Async reset between edges, then restart from zero.
    cycle(1'b0, 1'b1, 700);
    cycle(1'b0, 1'b1, 700);
    #2 rst = 1'b1;
    #1;
    check("async_rst_y", longint'(y), 0);
    check("async_rst_acc", dut_acc, 0);
    macc = 0;
    #1 rst = 1'b0;
    cycle(1'b0, 1'b1, 32);
    check("post_rst_acc", dut_acc, 32);
    check("post_rst_y", longint'(y), 1);

    // Random stimulus against the model.
    ok = 1'b1;
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), int'($urandom));
      if (dut_acc !== macc || longint'(y) !== floor_div(macc, SCALE)) ok = 1'b0;
      if (!ok) begin
        check($sformatf("random_cycle%0d_acc", i), dut_acc, macc);
        break;
      end
    end
    check("random_final_y", longint'(y), floor_div(macc, SCALE));

    // Convergence to a positive constant, then decay to zero.
    cycle(1'b1, 1'b0, 0);
    ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      cycle(1'b0, 1'b1, 1000);
      if (y > 1000) ok = 1'b0;
    end
    check("conv_no_overshoot", longint'(ok), 1);
    check("conv_settled", longint'((y == 1000) || (y == 999)), 1);
    check("conv_model", longint'(y), floor_div(macc, SCALE));
    ok   = 1'b1;
    prev = y;
    for (int i = 0; i < 1000; i++) begin
      cycle(1'b0, 1'b1, 0);
      if (longint'(y) > prev) ok = 1'b0;
      prev = y;
    end
    check("decay_monotonic", longint'(ok), 1);
    check("decay_settled", longint'((y == 0) || (y == -1)), 1);

    // Full-scale positive, then full-scale negative: no sign flip, no wrap.
    cycle(1'b1, 1'b0, 0);
    ok = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      cycle(1'b0, 1'b1, UMAX);
      if (y <= 0) ok = 1'b0;
    end
    check("sat_pos_positive", longint'(ok), 1);
    check("sat_pos_model", dut_acc, macc);
    ok   = 1'b1;
    prev = y;
    for (int i = 0; i < 2000; i++) begin
      cycle(1'b0, 1'b1, UMIN);
      if (longint'(y) > prev) ok = 1'b0;
      prev = y;
    end
    check("sat_neg_monotonic", longint'(ok), 1);
    check("sat_neg_negative", longint'(y < 0), 1);
    check("sat_neg_model", dut_acc, macc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
